// File: rtl/counter_scheduler.sv
// Shared BCD incrementer walking per-slot stopwatch counters held in a single-port RAM,
// with clear-all and a low-priority display read port on the same RAM.
module counter_scheduler #(
  parameter int SLOTS  = 11,
  parameter int DIGITS = 6,
  parameter int AW     = 4,
  localparam int W     = 4 * DIGITS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [SLOTS-1:0] en,
  input  logic             clr,
  input  logic             rd_req,
  input  logic [AW-1:0]    rd_sel,
  output logic             rd_valid,
  output logic [W-1:0]     rd_data,
  output logic             busy,
  output logic             overrun,
  output logic [AW-1:0]    mem_addr,
  output logic             mem_we,
  output logic [W-1:0]     mem_wdata,
  input  logic [W-1:0]     mem_rdata
);

  localparam int IW = $clog2(SLOTS + 1);

  typedef enum logic [2:0] {IDLE, SCAN, INC, DREAD, CLEAR} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [SLOTS-1:0] en_snap_q, en_snap_d;
  logic             tick_pend_q, tick_pend_d;
  logic             overrun_q, overrun_d;
  logic             rd_valid_q, rd_valid_d;
  logic [W-1:0]     rd_data_q, rd_data_d;

  // Corrupt digits (>9) roll to zero like a 9, so a bad word self-heals on its next count.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
    logic       carry;
    logic [3:0] dg;
    bcd_inc = v;
    carry   = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      dg = v[4*i +: 4];
      if (carry) begin
        if (dg >= 4'd9) begin
          bcd_inc[4*i +: 4] = 4'd0;
        end else begin
          bcd_inc[4*i +: 4] = dg + 4'd1;
          carry             = 1'b0;
        end
      end
    end
  endfunction

  // Display handshake: rd_req is a level held until rd_valid pulses for one cycle
  // with rd_data; the request is only taken in an IDLE cycle with no clr or tick.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    en_snap_d   = en_snap_q;
    tick_pend_d = tick_pend_q;
    overrun_d   = overrun_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    mem_addr    = AW'(idx_q);
    mem_we      = 1'b0;
    mem_wdata   = '0;

    if (tick && (state_q == SCAN || state_q == INC || state_q == DREAD)) begin
      if (tick_pend_q) overrun_d = 1'b1;
      else             tick_pend_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else if (tick || tick_pend_q) begin
          en_snap_d   = en;
          idx_d       = '0;
          tick_pend_d = 1'b0;
          state_d     = SCAN;
        end else if (rd_req) begin
          mem_addr = rd_sel;
          state_d  = DREAD;
        end
      end
      DREAD: begin
        rd_data_d  = mem_rdata;
        rd_valid_d = 1'b1;
        state_d    = IDLE;
      end
      SCAN: begin
        if (idx_q == IW'(SLOTS)) begin
          if (tick_pend_q) begin
            // The pending tick is consumed here, so a fresh tick this cycle just re-arms it.
            tick_pend_d = tick;
            overrun_d   = overrun_q;
            en_snap_d   = en;
            idx_d       = '0;
          end else begin
            state_d = IDLE;
          end
        end else if (en_snap_q[idx_q]) begin
          state_d = INC;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      INC: begin
        mem_we    = 1'b1;
        mem_wdata = bcd_inc(mem_rdata);
        idx_d     = idx_q + 1'b1;
        state_d   = SCAN;
      end
      CLEAR: begin
        mem_we = 1'b1;
        if (idx_q == IW'(SLOTS - 1)) begin
          state_d     = IDLE;
          idx_d       = '0;
          tick_pend_d = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = CLEAR;
    endcase

    if (clr) begin
      state_d    = CLEAR;
      idx_d      = '0;
      mem_we     = 1'b0;
      rd_valid_d = 1'b0;
    end
    if (reset) mem_we = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= CLEAR;
      idx_q       <= '0;
      en_snap_q   <= '0;
      tick_pend_q <= 1'b0;
      overrun_q   <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      en_snap_q   <= en_snap_d;
      tick_pend_q <= tick_pend_d;
      overrun_q   <= overrun_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign overrun  = overrun_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_counter_scheduler.sv
// Randomized bench for counter_scheduler: behavioural RAM plus a decimal-rule reference
// model of the slot counters, checking writes, pass lengths, reads, clr and overrun.
module tb_counter_scheduler;

  localparam int SLOTS  = 11;
  localparam int DIGITS = 6;
  localparam int AW     = 4;
  localparam int W      = 4 * DIGITS;

  logic             clk = 1'b0;
  logic             reset, tick, clr, rd_req;
  logic [SLOTS-1:0] en;
  logic [AW-1:0]    rd_sel;
  logic             rd_valid, busy, overrun, mem_we;
  logic [W-1:0]     rd_data, mem_wdata, mem_rdata;
  logic [AW-1:0]    mem_addr;

  logic             bd_we;
  logic [AW-1:0]    bd_addr;
  logic [W-1:0]     bd_data;
  logic [W-1:0]     ram [16];
  logic [W-1:0]     model_mem [SLOTS];

  int checks = 0;
  int errors = 0;

  counter_scheduler #(.SLOTS(SLOTS), .DIGITS(DIGITS), .AW(AW)) dut (
    .clk(clk), .reset(reset), .tick(tick), .en(en), .clr(clr),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_valid(rd_valid), .rd_data(rd_data),
    .busy(busy), .overrun(overrun), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Single-port synchronous RAM, read data one cycle after the address; bd_* preloads it.
  always @(posedge clk) begin
    if (bd_we)       ram[bd_addr]  <= bd_data;
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference increment: the lowest digit below 9 goes up by one, every digit under it becomes 0.
  function automatic logic [W-1:0] ref_inc(input logic [W-1:0] v);
    logic [W-1:0] r;
    int k;
    k = DIGITS;
    for (int i = DIGITS - 1; i >= 0; i--) if (v[4*i +: 4] < 4'd9) k = i;
    if (k == DIGITS) return '0;
    r = v;
    for (int i = 0; i < k; i++) r[4*i +: 4] = 4'd0;
    r[4*k +: 4] = v[4*k +: 4] + 4'd1;
    return r;
  endfunction

  function automatic logic [W-1:0] random_bcd();
    logic [W-1:0] r;
    for (int i = 0; i < DIGITS; i++)
      r[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd9 : 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int a, input logic [W-1:0] v);
    bd_addr = AW'(a);
    bd_data = v;
    bd_we   = 1'b1;
    step();
    bd_we        = 1'b0;
    model_mem[a] = v;
  endtask

  task automatic check_mem(input string tag);
    for (int s = 0; s < SLOTS; s++)
      check_eq($sformatf("%s_slot%0d", tag, s), ram[s], model_mem[s]);
  endtask

  task automatic model_clear();
    for (int s = 0; s < SLOTS; s++) model_mem[s] = '0;
  endtask

  task automatic model_pass(input logic [SLOTS-1:0] mask);
    for (int s = 0; s < SLOTS; s++) if (mask[s]) model_mem[s] = ref_inc(model_mem[s]);
  endtask

  function automatic int pass_len(input logic [SLOTS-1:0] mask);
    int n;
    n = 1;
    for (int s = 0; s < SLOTS; s++) n += mask[s] ? 2 : 1;
    return n;
  endfunction

  task automatic run_pass(input logic [SLOTS-1:0] mask, input logic [SLOTS-1:0] mid_mask,
                          input string tag);
    int n;
    en   = mask;
    tick = 1'b1;
    step();
    tick = 1'b0;
    en   = mid_mask;
    n    = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    check_eq({tag, "_cycles"}, n, pass_len(mask));
    model_pass(mask);
    check_mem(tag);
  endtask

  task automatic display_read(input int sel, input string tag);
    int n;
    rd_sel = AW'(sel);
    rd_req = 1'b1;
    n      = 0;
    do begin
      step();
      n++;
    end while (!rd_valid && n < 10);
    rd_req = 1'b0;
    check_eq({tag, "_lat"}, n, 2);
    check_eq({tag, "_data"}, rd_data, model_mem[sel]);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    check_eq({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    reset = 1'b1; tick = 1'b0; clr = 1'b0; rd_req = 1'b0; rd_sel = '0; en = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;

    // Reset values, then the mandatory clear sweep
    repeat (2) step();
    check_eq("rst_busy", busy, 1'b1);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_overrun", overrun, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_rd_data", rd_data, 0);
    reset = 1'b0;
    #1;
    for (int i = 0; i < SLOTS; i++) begin
      check_eq($sformatf("clr_we%0d", i), mem_we, 1'b1);
      check_eq($sformatf("clr_addr%0d", i), mem_addr, i);
      check_eq($sformatf("clr_wdata%0d", i), mem_wdata, 0);
      step();
    end
    check_eq("clr_done_busy", busy, 1'b0);
    check_eq("clr_done_we", mem_we, 1'b0);
    model_clear();
    check_mem("after_reset");

    // Slots 0 and 10, with a decimal carry in slot 0
    preload(0, 24'h000009);
    run_pass(11'h401, 11'h401, "pass401");
    check_eq("pass401_slot0_val", ram[0], 24'h000010);
    check_eq("pass401_slot10_val", ram[10], 24'h000001);

    // Full wrap and corrupt-digit normalisation
    preload(3, 24'h999999);
    run_pass(11'h008, 11'h008, "wrap");
    check_eq("wrap_val", ram[3], 24'h000000);
    preload(3, 24'h00000F);
    run_pass(11'h008, 11'h008, "corrupt");
    check_eq("corrupt_val", ram[3], 24'h000010);

    // tick and display read in the same IDLE cycle: pass first, then the read
    preload(2, 24'h000129);
    en = 11'h006; rd_sel = 2; rd_req = 1'b1; tick = 1'b1;
    step();
    tick = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      n++;
      step();
    end
    check_eq("tickrd_cycles", n, pass_len(11'h006));
    model_pass(11'h006);
    step();
    check_eq("tickrd_dread_valid", rd_valid, 1'b0);
    step();
    check_eq("tickrd_valid", rd_valid, 1'b1);
    check_eq("tickrd_data", rd_data, model_mem[2]);
    rd_req = 1'b0;

    // clr during the INC of slot 4: the write is dropped, a tick during the clear is discarded
    preload(4, 24'h000457);
    en = 11'h030; tick = 1'b1;
    step();
    tick = 1'b0;
    n = 0;
    while (!(mem_we && mem_addr == 4) && n < 30) begin
      n++;
      step();
    end
    check_eq("abort_found_inc", (n < 30), 1'b1);
    clr = 1'b1;
    #1;
    check_eq("abort_we_gated", mem_we, 1'b0);
    step();
    clr = 1'b0;
    check_eq("abort_no_write", ram[4], 24'h000457);
    check_eq("abort_busy", busy, 1'b1);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_idle("abort_clear");
    step();
    check_eq("abort_tick_dropped", busy, 1'b0);
    check_eq("abort_overrun", overrun, 1'b0);
    model_clear();
    for (int s = 0; s < SLOTS; s++) display_read(s, $sformatf("abort_rd%0d", s));

    // Overrun: second tick is queued, third is lost
    en = '1; tick = 1'b1;
    step();
    tick = 1'b0;
    n = 0;
    while (busy && n < 200) begin
      tick = (n == 5 || n == 15);
      if (n == 10) check_eq("ovr_after_2nd", overrun, 1'b0);
      step();
      tick = 1'b0;
      n++;
    end
    check_eq("ovr_cycles", n, 2 * pass_len('1));
    check_eq("ovr_flag", overrun, 1'b1);
    model_pass('1);
    model_pass('1);
    check_mem("ovr");
    display_read(7, "ovr_rd7");
    check_eq("ovr_sticky", overrun, 1'b1);

    // Reset clears overrun and reruns the clear sweep
    reset = 1'b1;
    step();
    check_eq("rst2_overrun_dur", overrun, 1'b0);
    reset = 1'b0;
    step();
    wait_idle("rst2");
    check_eq("rst2_overrun", overrun, 1'b0);
    model_clear();
    check_mem("rst2");

    // Randomized passes with en changing mid-pass, plus random display reads
    for (int it = 0; it < 15; it++) begin
      logic [SLOTS-1:0] m, mid;
      preload($urandom_range(0, SLOTS - 1), random_bcd());
      preload($urandom_range(0, SLOTS - 1), random_bcd());
      m   = SLOTS'($urandom);
      mid = SLOTS'($urandom);
      run_pass(m, mid, $sformatf("rnd%0d", it));
      display_read($urandom_range(0, SLOTS - 1), $sformatf("rnd%0d_rdA", it));
      display_read($urandom_range(0, SLOTS - 1), $sformatf("rnd%0d_rdB", it));
    end
    check_eq("final_overrun", overrun, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
